hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Producer-side hazard controller for the 5-stage core; the counterpart to operand forwarding.
- Decides when the pipeline must not advance: load-use, pending multi-cycle (MDU) writebacks, AXI memory wait. Decides when younger stages are squashed on a taken branch.
- Holds a register scoreboard and a memory-wait watchdog. Drives the write enables and flushes of the PC and all pipeline registers.

Parameters:
- TIMEOUT_CYC, 1024, freeze cycles before mem_timeout is raised; minimum 2.
- XLEN_REGS, 32, architectural register count; scoreboard width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- rs1_if_id  in  5  rs1 of instruction in ID
- rs2_if_id  in  5  rs2 of instruction in ID
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rd_if_id  in  5  destination of ID instruction
- reg_write_id  in  1  ID instruction writes rd
- mdu_op_id  in  1  ID instruction is a multi-cycle MDU op
- rd_id_ex  in  5  destination in EX
- mem_read_id_ex  in  1  EX instruction is a load
- branch_taken_ex  in  1  EX resolved taken branch/jump
- im_stall  in  1  instruction AXI fetch not yet returned
- dm_stall  in  1  data AXI access not yet complete
- mdu_wb_valid  in  1  MDU result written to regfile this cycle
- mdu_wb_rd  in  5  destination of that result
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID enable
- id_ex_write  out  1  ID/EX enable
- ex_mem_write  out  1  EX/MEM enable
- mem_wb_write  out  1  MEM/WB enable
- if_id_flush  out  1  squash IF/ID
- id_ex_flush  out  1  insert bubble into ID/EX
- sb_pending  out  32  scoreboard vector, bit0 always 0
- mem_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (rst_n low, async): sb_pending=0, freeze counter=0, mem_timeout=0. Outputs combinational from state, so after reset all *_write=1 and flushes=0.
- freeze = im_stall | dm_stall.
  - All five *_write=0. Both flushes=0.
  - A branch_taken_ex during freeze is not lost: EX is held, so it is applied on the first unfrozen cycle.
- pend_eff = sb_pending & ~(mdu_wb_valid ? onehot(mdu_wb_rd) : 0). A same-cycle writeback releases the consumer; the regfile writes through.
- load_use = mem_read_id_ex & rd_id_ex!=0 & ((use_rs1_id & rs1_if_id==rd_id_ex) | (use_rs2_id & rs2_if_id==rd_id_ex)).
- sb_hit = (use_rs1_id & pend_eff[rs1]) | (use_rs2_id & pend_eff[rs2]) | (reg_write_id & pend_eff[rd_if_id]). The last term is the WAW case.
- Priority when not frozen:
  1. branch_taken_ex: if_id_flush=1, id_ex_flush=1, all writes=1. This overrides a stall because the ID instruction is squashed.
  2. load_use | sb_hit: pc_write=0, if_id_write=0, id_ex_flush=1; downstream writes=1.
  3. Otherwise all writes=1, no flush.
- Scoreboard update (clocked):
  - Set bit rd_if_id when mdu_op_id & reg_write_id & rd_if_id!=0 & ID advances: not frozen, no stall, no branch flush.
  - Clear bit mdu_wb_rd on mdu_wb_valid.
  - Same-register set and clear in one cycle: set wins.
  - Bit 0 is never set.
- Watchdog:
  - Counter increments while freeze and saturates at TIMEOUT_CYC; it clears on any unfrozen cycle.
  - mem_timeout sets when the counter reaches TIMEOUT_CYC-1 while still frozen.
  - mem_timeout is sticky until reset.
- Reset mid-stall: scoreboard and counter drop immediately; the pipeline restarts unstalled.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, adds three 32-bit saturating outputs, reset to 0:
  - perf_freeze_cyc counts frozen cycles.
  - perf_stall_cyc counts cycles with priority-2 active.
  - perf_flush_cnt counts priority-1 events.
- When undefined, these ports and their counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds REG_ADDR_W=5, NUM_REGS=32, and the x0 constant.
- One sub-module, hazard_scoreboard: pending vector, set/clear logic, and pend_eff output.
- Priority logic and watchdog live in the top module.

Test Plan:
- Load-use: EX load with rd=5, ID reads rs1=5 → one cycle of pc_write=0, if_id_write=0, id_ex_flush=1; ld rd=0 with rs1=0 → no stall.
- MDU: issue div rd=7 → sb_pending[7]=1. Next ID reads x7 → stalls until mdu_wb_valid with rd=7; released in that same cycle and bit cleared next edge.
- Branch vs stall: branch_taken_ex and load_use together → flushes=1, pc_write=1, no stall.
- Freeze: dm_stall high 3 cycles with branch_taken_ex → all writes=0, flushes=0 for 3 cycles; flush applied on cycle 4.
- Watchdog: TIMEOUT_CYC=4, im_stall held 4 cycles → mem_timeout=1 after the 4th frozen edge and stays 1 after im_stall drops; rst_n low clears it asynchronously.
- Set/clear race: issue to rd=9 while mdu_wb_rd=9 valid → sb_pending[9]=1 afterwards.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core constants and the hazard controller's per-cycle decision type.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

   typedef enum logic [1:0] {
      HZ_RUN    = 2'd0,
      HZ_STALL  = 2'd1,
      HZ_FLUSH  = 2'd2,
      HZ_FREEZE = 2'd3
   } hz_mode_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-writeback scoreboard for multi-cycle MDU results.
// pend_eff hides a register whose result is being written back this cycle.
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int XLEN_REGS = NUM_REGS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_rd,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_rd,
   output logic [XLEN_REGS-1:0]  pending,
   output logic [XLEN_REGS-1:0]  pend_eff
);

   logic [XLEN_REGS-1:0] set_mask;
   logic [XLEN_REGS-1:0] clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_rd != REG_X0))
         set_mask[set_rd] = 1'b1;
      if (clr_en)
         clr_mask[clr_rd] = 1'b1;
   end

   assign pend_eff = pending & ~clr_mask;

   // Set is OR-ed in after the clear so a same-register race keeps the bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pending <= '0;
      else
         pending <= (pending & ~clr_mask) | set_mask;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/scoreboard stalls, branch flush, AXI freeze, watchdog.
// Optional performance counters are enabled with `define HAZARD_PERF_EN.
//
// mode      | meaning
// HZ_RUN    | all stages advance
// HZ_STALL  | hold PC and IF/ID, bubble into ID/EX
// HZ_FLUSH  | taken branch in EX, squash IF/ID and ID/EX
// HZ_FREEZE | AXI wait, whole pipeline held
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 1024,
   parameter int XLEN_REGS   = NUM_REGS
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_if_id,
   input  logic [REG_ADDR_W-1:0] rs2_if_id,
   input  logic                  use_rs1_id,
   input  logic                  use_rs2_id,
   input  logic [REG_ADDR_W-1:0] rd_if_id,
   input  logic                  reg_write_id,
   input  logic                  mdu_op_id,
   input  logic [REG_ADDR_W-1:0] rd_id_ex,
   input  logic                  mem_read_id_ex,
   input  logic                  branch_taken_ex,
   input  logic                  im_stall,
   input  logic                  dm_stall,
   input  logic                  mdu_wb_valid,
   input  logic [REG_ADDR_W-1:0] mdu_wb_rd,
   output logic                  pc_write,
   output logic                  if_id_write,
   output logic                  id_ex_write,
   output logic                  ex_mem_write,
   output logic                  mem_wb_write,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic [XLEN_REGS-1:0]  sb_pending,
   output logic                  mem_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0]           perf_freeze_cyc,
   output logic [31:0]           perf_stall_cyc,
   output logic [31:0]           perf_flush_cnt
`endif
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] CNT_ARM = CNT_W'(TIMEOUT_CYC - 1);

   logic                 freeze;
   logic                 load_use;
   logic                 sb_hit;
   logic                 id_advance;
   logic [XLEN_REGS-1:0] pend_eff;
   logic [CNT_W-1:0]     frz_cnt;
   hz_mode_e             mode;

   assign freeze = im_stall | dm_stall;

   assign load_use = mem_read_id_ex && (rd_id_ex != REG_X0) &&
                     ((use_rs1_id && (rs1_if_id == rd_id_ex)) ||
                      (use_rs2_id && (rs2_if_id == rd_id_ex)));

   // Last term blocks a second MDU issue to a register still in flight (WAW).
   assign sb_hit = (use_rs1_id   && pend_eff[rs1_if_id]) ||
                   (use_rs2_id   && pend_eff[rs2_if_id]) ||
                   (reg_write_id && pend_eff[rd_if_id]);

   always_comb begin
      mode = HZ_RUN;
      if (freeze)
         mode = HZ_FREEZE;
      else if (branch_taken_ex)
         mode = HZ_FLUSH;
      else if (load_use || sb_hit)
         mode = HZ_STALL;
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      case (mode)
         HZ_FREEZE: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
         end
         HZ_FLUSH: begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         HZ_STALL: begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end
         default: ;
      endcase
   end

   assign id_advance = (mode == HZ_RUN);

   hazard_scoreboard #(
      .XLEN_REGS (XLEN_REGS)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (mdu_op_id && reg_write_id && id_advance),
      .set_rd   (rd_if_id),
      .clr_en   (mdu_wb_valid),
      .clr_rd   (mdu_wb_rd),
      .pending  (sb_pending),
      .pend_eff (pend_eff)
   );

   // Watchdog trips on the TIMEOUT_CYC-th consecutive frozen edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frz_cnt     <= '0;
         mem_timeout <= 1'b0;
      end else begin
         if (!freeze)
            frz_cnt <= '0;
         else if (frz_cnt != CNT_MAX)
            frz_cnt <= frz_cnt + 1'b1;
         if (freeze && (frz_cnt >= CNT_ARM))
            mem_timeout <= 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_freeze_cyc <= '0;
         perf_stall_cyc  <= '0;
         perf_flush_cnt  <= '0;
      end else begin
         if ((mode == HZ_FREEZE) && (perf_freeze_cyc != '1))
            perf_freeze_cyc <= perf_freeze_cyc + 1'b1;
         if ((mode == HZ_STALL) && (perf_stall_cyc != '1))
            perf_stall_cyc <= perf_stall_cyc + 1'b1;
         if ((mode == HZ_FLUSH) && (perf_flush_cnt != '1))
            perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run against a reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl;

   localparam int TMO = 4;

   logic        clk;
   logic        rst_n;
   logic [4:0]  rs1_if_id, rs2_if_id, rd_if_id, rd_id_ex, mdu_wb_rd;
   logic        use_rs1_id, use_rs2_id, reg_write_id, mdu_op_id;
   logic        mem_read_id_ex, branch_taken_ex, im_stall, dm_stall, mdu_wb_valid;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
   logic        if_id_flush, id_ex_flush, mem_timeout;
   logic [31:0] sb_pending;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_freeze_cyc, perf_stall_cyc, perf_flush_cnt;
`endif

   logic [4:0] wr;
   logic [1:0] fl;
   assign wr = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write};
   assign fl = {if_id_flush, id_ex_flush};

   int errors = 0;
   int checks = 0;

   hazard_ctrl #(.TIMEOUT_CYC(TMO), .XLEN_REGS(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .rs1_if_id       (rs1_if_id),
      .rs2_if_id       (rs2_if_id),
      .use_rs1_id      (use_rs1_id),
      .use_rs2_id      (use_rs2_id),
      .rd_if_id        (rd_if_id),
      .reg_write_id    (reg_write_id),
      .mdu_op_id       (mdu_op_id),
      .rd_id_ex        (rd_id_ex),
      .mem_read_id_ex  (mem_read_id_ex),
      .branch_taken_ex (branch_taken_ex),
      .im_stall        (im_stall),
      .dm_stall        (dm_stall),
      .mdu_wb_valid    (mdu_wb_valid),
      .mdu_wb_rd       (mdu_wb_rd),
      .pc_write        (pc_write),
      .if_id_write     (if_id_write),
      .id_ex_write     (id_ex_write),
      .ex_mem_write    (ex_mem_write),
      .mem_wb_write    (mem_wb_write),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .sb_pending      (sb_pending),
      .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .perf_freeze_cyc (perf_freeze_cyc),
      .perf_stall_cyc  (perf_stall_cyc),
      .perf_flush_cnt  (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit reached");
      $fatal(1);
   end

   task automatic idle();
      rs1_if_id = 0; rs2_if_id = 0; rd_if_id = 0; rd_id_ex = 0; mdu_wb_rd = 0;
      use_rs1_id = 0; use_rs2_id = 0; reg_write_id = 0; mdu_op_id = 0;
      mem_read_id_ex = 0; branch_taken_ex = 0; im_stall = 0; dm_stall = 0;
      mdu_wb_valid = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      idle();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (wr !== 5'b11111) begin errors++; $display("FAIL reset_writes got=%b exp=11111", wr); end
      checks++; if (fl !== 2'b00) begin errors++; $display("FAIL reset_flush got=%b exp=00", fl); end
      checks++; if (sb_pending !== 32'h0) begin errors++; $display("FAIL reset_sb got=%h exp=0", sb_pending); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", mem_timeout); end
   endtask

   task automatic test_load_use();
      do_reset();
      mem_read_id_ex = 1; rd_id_ex = 5; use_rs1_id = 1; rs1_if_id = 5;
      #1;
      checks++; if (wr !== 5'b00111) begin errors++; $display("FAIL load_use_writes got=%b exp=00111", wr); end
      checks++; if (fl !== 2'b01) begin errors++; $display("FAIL load_use_flush got=%b exp=01", fl); end
      @(negedge clk);
      rd_id_ex = 0; rs1_if_id = 0;
      #1;
      checks++; if (wr !== 5'b11111 || fl !== 2'b00) begin errors++; $display("FAIL load_x0 got=%b/%b exp=11111/00", wr, fl); end
      @(negedge clk);
      rd_id_ex = 6; rs1_if_id = 1; use_rs2_id = 1; rs2_if_id = 6;
      #1;
      checks++; if (wr !== 5'b00111 || fl !== 2'b01) begin errors++; $display("FAIL load_use_rs2 got=%b/%b exp=00111/01", wr, fl); end
   endtask

   task automatic test_mdu();
      do_reset();
      mdu_op_id = 1; reg_write_id = 1; rd_if_id = 7;
      #1;
      checks++; if (wr !== 5'b11111) begin errors++; $display("FAIL mdu_issue_writes got=%b exp=11111", wr); end
      @(negedge clk);
      idle(); use_rs1_id = 1; rs1_if_id = 7;
      #1;
      checks++; if (sb_pending !== 32'h0000_0080) begin errors++; $display("FAIL mdu_sb_set got=%h exp=00000080", sb_pending); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (wr !== 5'b00111 || fl !== 2'b01) begin errors++; $display("FAIL mdu_stall_%0d got=%b/%b exp=00111/01", k, wr, fl); end
         @(negedge clk);
         #1;
      end
      mdu_wb_valid = 1; mdu_wb_rd = 7;
      #1;
      checks++; if (wr !== 5'b11111 || fl !== 2'b00) begin errors++; $display("FAIL mdu_release got=%b/%b exp=11111/00", wr, fl); end
      checks++; if (sb_pending[7] !== 1'b1) begin errors++; $display("FAIL mdu_bit_held got=%b exp=1", sb_pending[7]); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (sb_pending !== 32'h0) begin errors++; $display("FAIL mdu_bit_clear got=%h exp=0", sb_pending); end
      mdu_op_id = 1; reg_write_id = 1; rd_if_id = 0;
      @(negedge clk);
      idle();
      #1;
      checks++; if (sb_pending !== 32'h0) begin errors++; $display("FAIL mdu_x0_never_set got=%h exp=0", sb_pending); end
   endtask

   task automatic test_branch_vs_stall();
      do_reset();
      mem_read_id_ex = 1; rd_id_ex = 3; use_rs1_id = 1; rs1_if_id = 3; branch_taken_ex = 1;
      mdu_op_id = 1; reg_write_id = 1; rd_if_id = 4;
      #1;
      checks++; if (wr !== 5'b11111 || fl !== 2'b11) begin errors++; $display("FAIL branch_over_stall got=%b/%b exp=11111/11", wr, fl); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (sb_pending !== 32'h0) begin errors++; $display("FAIL branch_no_issue got=%h exp=0", sb_pending); end
   endtask

   task automatic test_freeze();
      do_reset();
      branch_taken_ex = 1; dm_stall = 1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (wr !== 5'b00000 || fl !== 2'b00) begin errors++; $display("FAIL freeze_%0d got=%b/%b exp=00000/00", k, wr, fl); end
         @(negedge clk);
      end
      dm_stall = 0;
      #1;
      checks++; if (wr !== 5'b11111 || fl !== 2'b11) begin errors++; $display("FAIL freeze_branch_after got=%b/%b exp=11111/11", wr, fl); end
   endtask

   task automatic test_watchdog();
      do_reset();
      im_stall = 1;
      for (int k = 1; k <= TMO; k++) begin
         @(posedge clk);
         #1;
         checks++; if (mem_timeout !== (k == TMO)) begin errors++; $display("FAIL watchdog_edge_%0d got=%b exp=%b", k, mem_timeout, (k == TMO)); end
         @(negedge clk);
      end
      im_stall = 0;
      @(posedge clk);
      #1;
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL watchdog_sticky got=%b exp=1", mem_timeout); end
      checks++; if (wr !== 5'b11111) begin errors++; $display("FAIL watchdog_unfrozen got=%b exp=11111", wr); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL watchdog_async_clear got=%b exp=0", mem_timeout); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_race();
      do_reset();
      mdu_op_id = 1; reg_write_id = 1; rd_if_id = 9;
      @(negedge clk);
      mdu_wb_valid = 1; mdu_wb_rd = 9;
      #1;
      checks++; if (wr !== 5'b11111) begin errors++; $display("FAIL race_no_waw_stall got=%b exp=11111", wr); end
      @(negedge clk);
      idle();
      #1;
      checks++; if (sb_pending !== 32'h0000_0200) begin errors++; $display("FAIL race_set_wins got=%h exp=00000200", sb_pending); end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      mdu_op_id = 1; reg_write_id = 1; rd_if_id = 3;
      @(negedge clk);
      idle(); im_stall = 1; use_rs1_id = 1; rs1_if_id = 3;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (sb_pending !== 32'h0) begin errors++; $display("FAIL midstall_sb got=%h exp=0", sb_pending); end
      @(negedge clk);
      im_stall = 0;
      rst_n = 1'b1;
      #1;
      checks++; if (wr !== 5'b11111 || fl !== 2'b00) begin errors++; $display("FAIL midstall_restart got=%b/%b exp=11111/00", wr, fl); end
   endtask

   task automatic test_random();
      bit pend[32];
      int frz_run, n_frz, n_stall, n_flush;
      bit tmo;
      bit frz, lu, hit, hold;
      bit eff[32];
      logic [4:0]  exp_wr;
      logic [1:0]  exp_fl;
      logic [31:0] exp_sb;
      do_reset();
      foreach (pend[i]) pend[i] = 0;
      frz_run = 0; tmo = 0; n_frz = 0; n_stall = 0; n_flush = 0; hold = 0;
      for (int n = 0; n < 800; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) == 0) begin
            rst_n = 1'b0;
            #1;
            checks++; if (sb_pending !== 32'h0 || mem_timeout !== 1'b0) begin errors++; $display("FAIL rand_reset_%0d sb=%h tmo=%b exp=0/0", n, sb_pending, mem_timeout); end
            foreach (pend[i]) pend[i] = 0;
            frz_run = 0; tmo = 0; n_frz = 0; n_stall = 0; n_flush = 0;
            #1;
            rst_n = 1'b1;
         end
         rs1_if_id = 5'($urandom_range(0, 7));
         rs2_if_id = 5'($urandom_range(0, 7));
         rd_if_id  = 5'($urandom_range(0, 7));
         rd_id_ex  = 5'($urandom_range(0, 7));
         mdu_wb_rd = 5'($urandom_range(0, 7));
         use_rs1_id      = ($urandom_range(0, 1) == 1);
         use_rs2_id      = ($urandom_range(0, 1) == 1);
         reg_write_id    = ($urandom_range(0, 1) == 1);
         mdu_op_id       = ($urandom_range(0, 9) < 4);
         mem_read_id_ex  = ($urandom_range(0, 9) < 3);
         branch_taken_ex = ($urandom_range(0, 9) == 0);
         mdu_wb_valid    = ($urandom_range(0, 9) < 3);
         hold = hold ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) == 0);
         im_stall = hold && ($urandom_range(0, 1) == 1);
         dm_stall = hold && !im_stall;
         #1;
         frz = im_stall || dm_stall;
         foreach (eff[i]) eff[i] = pend[i] && !(mdu_wb_valid && (mdu_wb_rd == i));
         lu  = mem_read_id_ex && (rd_id_ex != 0) &&
               ((use_rs1_id && rs1_if_id == rd_id_ex) || (use_rs2_id && rs2_if_id == rd_id_ex));
         hit = (use_rs1_id && eff[rs1_if_id]) || (use_rs2_id && eff[rs2_if_id]) ||
               (reg_write_id && eff[rd_if_id]);
         if (frz)                  begin exp_wr = 5'b00000; exp_fl = 2'b00; end
         else if (branch_taken_ex) begin exp_wr = 5'b11111; exp_fl = 2'b11; end
         else if (lu || hit)       begin exp_wr = 5'b00111; exp_fl = 2'b01; end
         else                      begin exp_wr = 5'b11111; exp_fl = 2'b00; end
         foreach (pend[i]) exp_sb[i] = pend[i];
         checks++; if (wr !== exp_wr) begin errors++; $display("FAIL rand_writes_%0d got=%b exp=%b", n, wr, exp_wr); end
         checks++; if (fl !== exp_fl) begin errors++; $display("FAIL rand_flush_%0d got=%b exp=%b", n, fl, exp_fl); end
         checks++; if (sb_pending !== exp_sb) begin errors++; $display("FAIL rand_sb_%0d got=%h exp=%h", n, sb_pending, exp_sb); end
         checks++; if (mem_timeout !== tmo) begin errors++; $display("FAIL rand_timeout_%0d got=%b exp=%b", n, mem_timeout, tmo); end
`ifdef HAZARD_PERF_EN
         checks++;
         if (perf_freeze_cyc !== n_frz || perf_stall_cyc !== n_stall || perf_flush_cnt !== n_flush) begin
            errors++;
            $display("FAIL rand_perf_%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", n,
                     perf_freeze_cyc, perf_stall_cyc, perf_flush_cnt, n_frz, n_stall, n_flush);
         end
`endif
         if (mdu_wb_valid) pend[mdu_wb_rd] = 0;
         if (!frz && !branch_taken_ex && !lu && !hit && mdu_op_id && reg_write_id && rd_if_id != 0)
            pend[rd_if_id] = 1;
         if (frz) begin
            frz_run++;
            if (frz_run >= TMO) tmo = 1;
            n_frz++;
         end else begin
            frz_run = 0;
            if (branch_taken_ex) n_flush++;
            else if (lu || hit) n_stall++;
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      test_reset();
      test_load_use();
      test_mdu();
      test_branch_vs_stall();
      test_freeze();
      test_watchdog();
      test_race();
      test_reset_mid_stall();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
